// File: rtl/ysyx_22051013_fetch_redirect_ctrl_pkg.sv
// Shared widths, reset PC, FSM encoding and prediction-queue entry layout
// for the fetch redirect controller.
package ysyx_22051013_fetch_redirect_ctrl_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = PC_W + 1;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0] pred_next;
    logic            pred_taken;
  } pred_entry_t;

endpackage

// File: rtl/ysyx_22051013_pred_fifo.sv
// Synchronous FIFO of in-flight predictions; clear has priority over push/pop,
// and a pop frees a slot for a push in the same cycle when full.
module ysyx_22051013_pred_fifo
  import ysyx_22051013_fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  pred_entry_t wdata,
  output pred_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pred_entry_t      mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ysyx_22051013_fetch_redirect_ctrl.sv
// Fetch PC sequencer: follows predictor targets, checks them at resolve time
// and redirects with a fixed drain window on a misprediction.
module ysyx_22051013_fetch_redirect_ctrl
  import ysyx_22051013_fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH        = 4,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   fetch_pc_o,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  input  logic [PC_W-1:0]   bpu_pc_i,
  input  logic              bpu_jump_i,
  input  logic              res_valid_i,
  input  logic [PC_W-1:0]   res_next_pc_i,
  output logic              flush_o,
  output logic              queue_full_o,
  output logic [DATA_W-1:0] res_cnt_o,
  output logic [DATA_W-1:0] mispred_cnt_o,
  output logic [DATA_W-1:0] taken_cnt_o,
  output logic              err_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t          state_q;
  state_t          state_d;
  logic [FC_W-1:0] fcnt_q;
  logic [FC_W-1:0] fcnt_d;

  pred_entry_t     head;
  pred_entry_t     push_entry;
  logic            q_full;
  logic            q_empty;
  logic            fire;
  logic            resolve;
  logic            mispredict;

  assign fetch_valid_o = (state_q == ST_RUN) && !q_full;
  assign queue_full_o  = q_full;
  assign fire          = fetch_valid_o && fetch_ready_i;
  assign resolve       = res_valid_i && !q_empty;
  assign mispredict    = resolve && (res_next_pc_i != head.pred_next);
  assign push_entry    = '{pred_next: bpu_pc_i, pred_taken: bpu_jump_i};

  ysyx_22051013_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (mispredict),
    .push  (fire && !mispredict),
    .pop   (resolve),
    .wdata (push_entry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Redirect opens a FLUSH_CYCLES-long window in which fetch is held off.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Redirect wins over a same-cycle fire; the discarded push never reaches the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_o    <= RESET_PC;
      flush_o       <= 1'b0;
      res_cnt_o     <= '0;
      mispred_cnt_o <= '0;
      taken_cnt_o   <= '0;
      err_o         <= 1'b0;
    end else begin
      flush_o <= mispredict;
      if (mispredict) begin
        fetch_pc_o <= res_next_pc_i;
      end else if (fire) begin
        fetch_pc_o <= bpu_pc_i;
      end
      if (resolve) begin
        res_cnt_o   <= res_cnt_o + DATA_W'(1);
        taken_cnt_o <= taken_cnt_o + DATA_W'(head.pred_taken);
      end
      if (mispredict) begin
        mispred_cnt_o <= mispred_cnt_o + DATA_W'(1);
      end
      if (res_valid_i && q_empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_fetch_redirect_ctrl.sv
// Randomized bench for the fetch redirect controller against a queue-based
// behavioural model, with directed scenarios pinned by literal expectations.
module tb_ysyx_22051013_fetch_redirect_ctrl;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned FLUSH_N  = 2;
  localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fetch_pc_o;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [63:0] bpu_pc_i;
  logic        bpu_jump_i;
  logic        res_valid_i;
  logic [63:0] res_next_pc_i;
  logic        flush_o;
  logic        queue_full_o;
  logic [31:0] res_cnt_o;
  logic [31:0] mispred_cnt_o;
  logic [31:0] taken_cnt_o;
  logic        err_o;

  ysyx_22051013_fetch_redirect_ctrl #(
    .RESET_PC     (RST_PC),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .bpu_pc_i      (bpu_pc_i),
    .bpu_jump_i    (bpu_jump_i),
    .res_valid_i   (res_valid_i),
    .res_next_pc_i (res_next_pc_i),
    .flush_o       (flush_o),
    .queue_full_o  (queue_full_o),
    .res_cnt_o     (res_cnt_o),
    .mispred_cnt_o (mispred_cnt_o),
    .taken_cnt_o   (taken_cnt_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  int          m_hold;
  logic        m_flush;
  logic        m_err;
  logic [31:0] m_res;
  logic [31:0] m_mis;
  logic [31:0] m_taken;

  int checks = 0;
  int errors = 0;

  function automatic logic m_valid();
    return (m_hold == 0) && (mq.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RST_PC;
    m_hold  = 0;
    m_flush = 1'b0;
    m_err   = 1'b0;
    m_res   = '0;
    m_mis   = '0;
    m_taken = '0;
  endtask

  task automatic model_step(input logic r, input logic fired, input logic [63:0] bpc,
                            input logic bj, input logic rv, input logic [63:0] rpc);
    ent_t h;
    logic mis;
    if (r) begin
      model_reset();
      return;
    end
    mis     = 1'b0;
    m_flush = 1'b0;
    if (m_hold > 0) m_hold--;
    if (rv) begin
      if (mq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        h = mq.pop_front();
        m_res++;
        if (h.taken) m_taken++;
        if (rpc != h.pc) begin
          mis = 1'b1;
          m_mis++;
          mq.delete();
          m_pc    = rpc;
          m_flush = 1'b1;
          m_hold  = FLUSH_N;
        end
      end
    end
    if (fired && !mis) begin
      mq.push_back('{pc: bpc, taken: bj});
      m_pc = bpc;
    end
  endtask

  task automatic compare_all();
    chk("fetch_pc",    fetch_pc_o,            m_pc);
    chk("fetch_valid", 64'(fetch_valid_o),    64'(m_valid()));
    chk("flush",       64'(flush_o),          64'(m_flush));
    chk("queue_full",  64'(queue_full_o),     64'(mq.size() == DEPTH));
    chk("res_cnt",     64'(res_cnt_o),        64'(m_res));
    chk("mispred_cnt", 64'(mispred_cnt_o),    64'(m_mis));
    chk("taken_cnt",   64'(taken_cnt_o),      64'(m_taken));
    chk("err",         64'(err_o),            64'(m_err));
  endtask

  // One clock: drive at the falling edge, advance the model on the rising edge, compare just after.
  task automatic cyc(input logic r, input logic rdy, input logic [63:0] bpc, input logic bj,
                     input logic rv, input logic [63:0] rpc);
    logic v;
    rst           = r;
    fetch_ready_i = rdy;
    bpu_pc_i      = bpc;
    bpu_jump_i    = bj;
    res_valid_i   = rv;
    res_next_pc_i = rpc;
    v = m_valid();
    @(posedge clk);
    model_step(r, v && rdy, bpc, bj, rv, rpc);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic        r;
    logic        rdy;
    logic        bj;
    logic        rv;
    logic [63:0] bpc;
    logic [63:0] rpc;
    int          p;

    model_reset();
    cyc(1, 0, 0, 0, 0, 0);
    chk("lit_reset_pc", fetch_pc_o, 64'h8000_0000);
    chk("lit_reset_valid", 64'(fetch_valid_o), 64'd1);
    chk("lit_reset_cnt", 64'(res_cnt_o), 64'd0);

    repeat (3) cyc(0, 1, m_pc + 64'd4, 0, 0, 0);
    chk("lit_seq_pc", fetch_pc_o, 64'h8000_000C);
    chk("lit_seq_full", 64'(queue_full_o), 64'd0);

    cyc(0, 1, m_pc + 64'd4, 0, 0, 0);
    chk("lit_full", 64'(queue_full_o), 64'd1);
    chk("lit_full_valid", 64'(fetch_valid_o), 64'd0);
    cyc(0, 1, m_pc + 64'd4, 0, 0, 0);
    chk("lit_full_hold_pc", fetch_pc_o, 64'h8000_0010);
    cyc(0, 0, 0, 0, 1, 64'h8000_0004);
    chk("lit_resolve_cnt", 64'(res_cnt_o), 64'd1);
    chk("lit_resume_valid", 64'(fetch_valid_o), 64'd1);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 64'h8000_0100, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'h8000_0100);
    chk("lit_taken_cnt", 64'(taken_cnt_o), 64'd1);
    chk("lit_taken_mis", 64'(mispred_cnt_o), 64'd0);
    chk("lit_taken_flush", 64'(flush_o), 64'd0);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 64'h8000_0004, 0, 0, 0);
    cyc(0, 1, 64'h8000_0008, 0, 1, 64'h8000_0040);
    chk("lit_mis_flush", 64'(flush_o), 64'd1);
    chk("lit_mis_pc", fetch_pc_o, 64'h8000_0040);
    chk("lit_mis_cnt", 64'(mispred_cnt_o), 64'd1);
    chk("lit_mis_valid0", 64'(fetch_valid_o), 64'd0);
    cyc(0, 1, 64'h8000_0044, 0, 0, 0);
    chk("lit_mis_flush_end", 64'(flush_o), 64'd0);
    chk("lit_mis_valid1", 64'(fetch_valid_o), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_mis_valid2", 64'(fetch_valid_o), 64'd1);
    chk("lit_mis_pc_hold", fetch_pc_o, 64'h8000_0040);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'h1234);
    chk("lit_err_set", 64'(err_o), 64'd1);
    chk("lit_err_cnt", 64'(res_cnt_o), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_err_sticky", 64'(err_o), 64'd1);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 64'h8000_0004, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'h8000_0200);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lit_rst_flush_pc", fetch_pc_o, 64'h8000_0000);
    chk("lit_rst_flush_valid", 64'(fetch_valid_o), 64'd1);
    chk("lit_rst_flush_mis", 64'(mispred_cnt_o), 64'd0);
    chk("lit_rst_flush_flush", 64'(flush_o), 64'd0);

    p = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) p = int'($urandom_range(5, 70));
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) begin
        bpc = {32'h0, $urandom};
        bj  = 1'b1;
      end else begin
        bpc = m_pc + 64'd4;
        bj  = ($urandom_range(0, 9) == 0);
      end
      rpc = {$urandom, $urandom};
      if (mq.size() > 0) begin
        rv  = ($urandom_range(0, 99) < p);
        rpc = ($urandom_range(0, 4) == 0) ? (mq[0].pc ^ 64'h40) : mq[0].pc;
      end else begin
        rv = ($urandom_range(0, 199) == 0);
      end
      cyc(r, rdy, bpc, bj, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
